// File: rtl/uart_rx_pkg.sv
// Shared constants and FSM state type for the UART receiver.
// The PARITY state exists only when UART_RX_PARITY_EN is defined.
package uart_rx_pkg;

    localparam int OSR        = 16;
    localparam int SAMPLE_LO  = 7;
    localparam int SAMPLE_MID = 8;
    localparam int SAMPLE_HI  = 9;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_IDLE = 3'd4
`ifdef UART_RX_PARITY_EN
        ,
        ST_PARITY    = 3'd5
`endif
    } rx_state_t;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_baud_tick.sv
// Oversample tick generator: counts 0..div_i and emits a one-clock tick at div_i.
// Held at zero while clr_i is asserted, so the first tick lands div_i+1 clocks after release.
module uart_rx_baud_tick #(
    parameter int DIV_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 clr_i,
    input  logic [DIV_WIDTH-1:0] div_i,
    output logic                 tick_o
);

    logic [DIV_WIDTH-1:0] count_reg;
    logic [DIV_WIDTH-1:0] count_next;

    always_comb begin
        tick_o     = 1'b0;
        count_next = count_reg + DIV_WIDTH'(1);
        if (clr_i) begin
            count_next = '0;
        end else if (count_reg == div_i) begin
            tick_o     = 1'b1;
            count_next = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

endmodule

// File: rtl/uart_rx_core.sv
// 16x-oversampled UART receiver with 3-sample majority vote and a valid/ready output stage.
// Optional parity checking is compiled in with UART_RX_PARITY_EN.
module uart_rx_core
    import uart_rx_pkg::*;
#(
    parameter int DIV_WIDTH  = 16,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  en_i,
    input  logic [DIV_WIDTH-1:0]  div_i,
    input  logic                  rx_i,
`ifdef UART_RX_PARITY_EN
    input  logic                  par_en_i,
    input  logic                  par_odd_i,
    output logic                  parity_err_o,
`endif
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  frame_err_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic                  overrun_o,
    output logic                  busy_o
);

    localparam int SCNT_W = $clog2(OSR);
    localparam int BIT_W  = $clog2(DATA_WIDTH);

    rx_state_t state_reg;
    rx_state_t state_next;

    logic [1:0]            sync_reg;
    logic                  rx_s;
    logic                  tick;
    logic                  baud_clr;
    logic [SCNT_W-1:0]     sample_cnt_reg;
    logic [SCNT_W-1:0]     sample_cnt_next;
    logic                  samp_lo_reg;
    logic                  samp_mid_reg;
    logic                  decide;
    logic                  vote;
    logic [BIT_W-1:0]      bit_idx_reg;
    logic                  last_bit;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic                  shift_en;
    logic                  load_en;
    logic [DATA_WIDTH-1:0] data_reg;
    logic                  frame_err_reg;
    logic                  valid_reg;
    logic                  overrun_reg;
`ifdef UART_RX_PARITY_EN
    logic                  par_cap;
    logic                  par_err_frame_reg;
    logic                  parity_err_reg;
`endif

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync_reg <= 2'b11;
        end else begin
            sync_reg <= {sync_reg[0], rx_i};
        end
    end
    assign rx_s = sync_reg[1];

    assign baud_clr = !en_i || (state_reg == ST_IDLE);

    uart_rx_baud_tick #(
        .DIV_WIDTH(DIV_WIDTH)
    ) u_baud_tick (
        .clk_i  (clk_i),
        .rst_n_i(rst_n_i),
        .clr_i  (baud_clr),
        .div_i  (div_i),
        .tick_o (tick)
    );

    // Sample index is the post-increment count, so sample 9 is the 9th tick into a bit.
    assign sample_cnt_next = sample_cnt_reg + SCNT_W'(1);
    assign decide          = tick && (sample_cnt_next == SCNT_W'(SAMPLE_HI));
    assign vote            = majority3(samp_lo_reg, samp_mid_reg, rx_s);
    assign last_bit        = (bit_idx_reg == BIT_W'(DATA_WIDTH - 1));

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sample_cnt_reg <= '0;
            samp_lo_reg    <= 1'b1;
            samp_mid_reg   <= 1'b1;
        end else if (baud_clr) begin
            sample_cnt_reg <= '0;
        end else if (tick) begin
            sample_cnt_reg <= sample_cnt_next;
            if (sample_cnt_next == SCNT_W'(SAMPLE_LO)) begin
                samp_lo_reg <= rx_s;
            end
            if (sample_cnt_next == SCNT_W'(SAMPLE_MID)) begin
                samp_mid_reg <= rx_s;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (!en_i) begin
            state_next = ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (!rx_s) state_next = ST_START;
                end
                ST_START: begin
                    if (decide) state_next = vote ? ST_IDLE : ST_DATA;
                end
                ST_DATA: begin
                    if (decide && last_bit) begin
`ifdef UART_RX_PARITY_EN
                        state_next = par_en_i ? ST_PARITY : ST_STOP;
`else
                        state_next = ST_STOP;
`endif
                    end
                end
`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (decide) state_next = ST_STOP;
                end
`endif
                // A low line at the stop decision must not be mistaken for the next start bit.
                ST_STOP: begin
                    if (decide) state_next = rx_s ? ST_IDLE : ST_WAIT_IDLE;
                end
                ST_WAIT_IDLE: begin
                    if (rx_s) state_next = ST_IDLE;
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        busy_o   = (state_reg != ST_IDLE);
        shift_en = 1'b0;
        load_en  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_cap  = 1'b0;
`endif
        if (en_i) begin
            case (state_reg)
                ST_DATA:   shift_en = decide;
                ST_STOP:   load_en  = decide;
`ifdef UART_RX_PARITY_EN
                ST_PARITY: par_cap  = decide;
`endif
                default:   ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            bit_idx_reg <= '0;
            shift_reg   <= '0;
        end else begin
            if (state_reg == ST_START) begin
                bit_idx_reg <= '0;
            end else if (shift_en) begin
                bit_idx_reg <= bit_idx_reg + BIT_W'(1);
            end
            if (shift_en) begin
                shift_reg <= {vote, shift_reg[DATA_WIDTH-1:1]};
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            par_err_frame_reg <= 1'b0;
        end else if (state_reg == ST_IDLE) begin
            par_err_frame_reg <= 1'b0;
        end else if (par_cap) begin
            par_err_frame_reg <= vote ^ (^shift_reg) ^ par_odd_i;
        end
    end
`endif

    // Single-entry output stage; a load that lands on an accept replaces the byte in place.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            data_reg       <= '0;
            frame_err_reg  <= 1'b0;
            valid_reg      <= 1'b0;
            overrun_reg    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_reg <= 1'b0;
`endif
        end else begin
            overrun_reg <= 1'b0;
            if (load_en) begin
                if (!valid_reg || ready_i) begin
                    data_reg       <= shift_reg;
                    frame_err_reg  <= !vote;
                    valid_reg      <= 1'b1;
`ifdef UART_RX_PARITY_EN
                    parity_err_reg <= par_err_frame_reg;
`endif
                end else begin
                    overrun_reg <= 1'b1;
                end
            end else if (valid_reg && ready_i) begin
                valid_reg <= 1'b0;
            end
        end
    end

    assign data_o      = data_reg;
    assign frame_err_o = frame_err_reg;
    assign valid_o     = valid_reg;
    assign overrun_o   = overrun_reg;
`ifdef UART_RX_PARITY_EN
    assign parity_err_o = parity_err_reg;
`endif

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core; parity cases are compiled in with UART_RX_PARITY_EN.
module tb_uart_rx_core;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [15:0] div;
    logic        rx;
    logic        ready;
    logic [7:0]  data;
    logic        fe;
    logic        valid;
    logic        ovr;
    logic        busy;
    logic        par_err;
`ifdef UART_RX_PARITY_EN
    logic        par_en;
    logic        par_odd;
`endif

    int n_cmp   = 0;
    int n_err   = 0;
    int bit_cyc = 0;
    int rd_ptr  = 0;
    int acc_cnt = 0;
    int ovr_cnt = 0;
    int ovr0    = 0;
    logic [9:0] acc_mem [0:63];

    always #5 clk = ~clk;

    uart_rx_core #(
        .DIV_WIDTH (16),
        .DATA_WIDTH(8)
    ) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .en_i        (en),
        .div_i       (div),
        .rx_i        (rx),
`ifdef UART_RX_PARITY_EN
        .par_en_i    (par_en),
        .par_odd_i   (par_odd),
        .parity_err_o(par_err),
`endif
        .data_o      (data),
        .frame_err_o (fe),
        .valid_o     (valid),
        .ready_i     (ready),
        .overrun_o   (ovr),
        .busy_o      (busy)
    );

`ifndef UART_RX_PARITY_EN
    assign par_err = 1'b0;
`endif

    // Records every accepted byte as {parity_err, frame_err, data}; samples mid-cycle.
    always begin
        @(negedge clk);
        #1;
        if (rst_n && valid && ready) begin
            if (acc_cnt < 64) acc_mem[acc_cnt] = {par_err, fe, data};
            acc_cnt = acc_cnt + 1;
            $display("rx accept: data=0x%02h fe=%0b pe=%0b", data, fe, par_err);
        end
        if (rst_n && ovr) ovr_cnt = ovr_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic expect_byte(input string tag, input logic [9:0] exp);
        chk({tag, "_present"}, 32'(acc_cnt > rd_ptr), 32'd1);
        if (acc_cnt > rd_ptr) begin
            chk(tag, 32'(acc_mem[rd_ptr]), 32'(exp));
            rd_ptr++;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_val,
                             input logic use_par, input logic par_bit);
        $display("tx frame: data=0x%02h stop=%0b par=%0b/%0b", b, stop_val, use_par, par_bit);
        rx = 1'b0;
        idle(bit_cyc);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            idle(bit_cyc);
        end
        if (use_par) begin
            rx = par_bit;
            idle(bit_cyc);
        end
        rx = stop_val;
        idle(bit_cyc);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n   = 1'b0;
        en      = 1'b1;
        div     = 16'd53;
        bit_cyc = 16 * 54;
        rx      = 1'b1;
        ready   = 1'b1;
`ifdef UART_RX_PARITY_EN
        par_en  = 1'b0;
        par_odd = 1'b0;
`endif
        idle(3);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_data",  32'(data),  32'd0);
        chk("rst_fe",    32'(fe),    32'd0);
        chk("rst_ovr",   32'(ovr),   32'd0);
        chk("rst_busy",  32'(busy),  32'd0);
        rst_n = 1'b1;
        idle(5);

        // Nominal 0xA5 at div 53.
        send_byte(8'hA5, 1'b1, 1'b0, 1'b0);
        idle(bit_cyc);
        expect_byte("a5", {2'b00, 8'hA5});
        chk("a5_one_pulse", 32'(acc_cnt), 32'd1);
        chk("a5_busy", 32'(busy), 32'd0);

        div     = 16'd3;
        bit_cyc = 16 * 4;
        idle(10);

        // False start: 5 ticks low.
        rx = 1'b0;
        idle(5 * 4);
        chk("false_busy_hi", 32'(busy), 32'd1);
        rx = 1'b1;
        idle(2 * bit_cyc);
        chk("false_busy_lo", 32'(busy), 32'd0);
        chk("false_valid", 32'(valid), 32'd0);
        chk("false_no_byte", 32'(acc_cnt), 32'(rd_ptr));

        // Stop bit low, line held low one more bit time.
        send_byte(8'h3C, 1'b0, 1'b0, 1'b0);
        idle(bit_cyc);
        chk("brk_wait_busy", 32'(busy), 32'd1);
        expect_byte("brk_3c", {2'b01, 8'h3C});
        rx = 1'b1;
        idle(2 * bit_cyc);
        chk("brk_idle", 32'(busy), 32'd0);
        chk("brk_no_extra", 32'(acc_cnt), 32'(rd_ptr));

        // Overrun with ready low, then load coinciding with accept.
        ready = 1'b0;
        ovr0  = ovr_cnt;
        send_byte(8'h11, 1'b1, 1'b0, 1'b0);
        send_byte(8'h22, 1'b1, 1'b0, 1'b0);
        idle(16);
        chk("ovr_valid", 32'(valid), 32'd1);
        chk("ovr_data_held", 32'(data), 32'h11);
        chk("ovr_pulse", 32'(ovr_cnt - ovr0), 32'd1);
        @(negedge clk);
        fork
            send_byte(8'h33, 1'b1, 1'b0, 1'b0);
            begin
                idle(2 + 153 * (int'(div) + 1));
                ready = 1'b1;
            end
        join
        idle(bit_cyc);
        expect_byte("ovr_11", {2'b00, 8'h11});
        expect_byte("ovr_33", {2'b00, 8'h33});
        chk("ovr_no_second", 32'(ovr_cnt - ovr0), 32'd1);
        chk("ovr_22_dropped", 32'(acc_cnt), 32'(rd_ptr));

        // Disable during bit 4 of 0x55.
        @(negedge clk);
        fork
            send_byte(8'h55, 1'b1, 1'b0, 1'b0);
            begin
                idle(5 * bit_cyc + bit_cyc / 2);
                en = 1'b0;
                idle(2);
                chk("dis_busy", 32'(busy), 32'd0);
            end
        join
        idle(bit_cyc);
        chk("dis_no_byte", 32'(acc_cnt), 32'(rd_ptr));
        en = 1'b1;
        idle(10);
        send_byte(8'h0F, 1'b1, 1'b0, 1'b0);
        idle(bit_cyc);
        expect_byte("reen_0f", {2'b00, 8'h0F});
        chk("reen_no_extra", 32'(acc_cnt), 32'(rd_ptr));

        // Asynchronous reset mid-frame with a pending byte.
        ready = 1'b0;
        send_byte(8'h99, 1'b1, 1'b0, 1'b0);
        idle(16);
        chk("ar_pending", 32'(data), 32'h99);
        @(negedge clk);
        fork
            send_byte(8'h66, 1'b1, 1'b0, 1'b0);
            begin
                idle(3 * bit_cyc);
                rst_n = 1'b0;
                #1;
                chk("ar_valid", 32'(valid), 32'd0);
                chk("ar_data", 32'(data), 32'd0);
                chk("ar_busy", 32'(busy), 32'd0);
            end
        join
        rst_n = 1'b1;
        ready = 1'b1;
        idle(bit_cyc);
        chk("ar_no_partial", 32'(acc_cnt), 32'(rd_ptr));
        chk("ar_valid_after", 32'(valid), 32'd0);

`ifdef UART_RX_PARITY_EN
        // Odd parity: 0x07 needs parity bit 0; a 1 is a mismatch.
        par_en  = 1'b1;
        par_odd = 1'b1;
        idle(10);
        send_byte(8'h07, 1'b1, 1'b1, 1'b1);
        idle(bit_cyc);
        expect_byte("par_bad", {2'b10, 8'h07});
        send_byte(8'h07, 1'b1, 1'b1, 1'b0);
        idle(bit_cyc);
        expect_byte("par_good", {2'b00, 8'h07});
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
